// File: rtl/bus_control_fsm.sv
// Initiator-side control unit for the shared 16-bit bus: fetches a 9-bit
// instruction and sequences T0..T3. Optional trap: BUS_CTRL_ILLEGAL_TRAP_EN.
module bus_control_fsm #(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] DIN,
  output logic [IR_W-1:0]   IR,
  output logic [7:0]        Rout,
  output logic              Gout,
  output logic              DINout,
  output logic [7:0]        Rin,
  output logic              Ain,
  output logic              Gin,
  output logic              AddSub,
  output logic              Done
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
  ,
  output logic              Error
`endif
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t          state_reg;
  logic [IR_W-1:0] ir_reg;
  logic [2:0]      opcode;
  logic [2:0]      rx;
  logic [2:0]      ry;

  // Only the low instruction bits of DIN are ever latched.
  logic unused_din;
  assign unused_din = ^DIN[DATA_W-1:IR_W];

  assign opcode = ir_reg[8:6];
  assign rx     = ir_reg[5:3];
  assign ry     = ir_reg[2:0];
  assign IR     = ir_reg;

  // Register n is bit (7-n), so R0 lands in the MSB.
  function automatic logic [7:0] onehot(input logic [2:0] n);
    logic [7:0] v;
    v = 8'b1000_0000 >> n;
    return v;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= T0;
      ir_reg    <= '0;
    end else begin
      case (state_reg)
        T0: begin
          if (Run) begin
            ir_reg    <= DIN[IR_W-1:0];
            state_reg <= T1;
          end
        end
        T1: begin
          case (opcode)
            OP_MV, OP_MVI:  state_reg <= T0;
            OP_ADD, OP_SUB: state_reg <= T2;
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
            default:        state_reg <= T1;
`else
            default:        state_reg <= T0;
`endif
          endcase
        end
        T2: state_reg <= T3;
        T3: state_reg <= T0;
        default: state_reg <= T0;
      endcase
    end
  end

  // Controls decode only registered state/IR, so DIN never reaches an output.
  always_comb begin
    Rout   = '0;
    Rin    = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    Done   = 1'b0;
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    Error  = 1'b0;
`endif
    if (!Reset) begin
      case (state_reg)
        T1: begin
          case (opcode)
            OP_MV: begin
              Rout = onehot(ry);
              Rin  = onehot(rx);
              Done = 1'b1;
            end
            OP_MVI: begin
              DINout = 1'b1;
              Rin    = onehot(rx);
              Done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              Rout = onehot(rx);
              Ain  = 1'b1;
            end
            default: begin
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
              // FSM parks here until reset, which keeps Error sticky.
              Error = 1'b1;
`else
              Done  = 1'b1;
`endif
            end
          endcase
        end
        T2: begin
          Rout   = onehot(ry);
          Gin    = 1'b1;
          AddSub = opcode[0];
        end
        T3: begin
          Gout = 1'b1;
          Rin  = onehot(rx);
          Done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_control_fsm.sv
// Scoreboard bench for bus_control_fsm: stimulus queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_bus_control_fsm;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Run   = 1'b0;
  logic [15:0] DIN   = '0;
  logic [8:0]  IR;
  logic [7:0]  Rout;
  logic        Gout;
  logic        DINout;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        Done;
  logic        err_sig;

  always #5 Clock = ~Clock;

  bus_control_fsm #(.DATA_W(16), .IR_W(9)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .IR     (IR),
    .Rout   (Rout),
    .Gout   (Gout),
    .DINout (DINout),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done)
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    ,
    .Error  (err_sig)
`endif
  );

`ifndef BUS_CTRL_ILLEGAL_TRAP_EN
  assign err_sig = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] ir;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  exp_t mon_got;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  function automatic exp_t mk(input logic [8:0] ir, input logic [7:0] rout,
                              input logic gout, input logic dinout,
                              input logic [7:0] rin, input logic ain,
                              input logic gin, input logic addsub,
                              input logic done, input logic err);
    exp_t e;
    e = '{ir, rout, gout, dinout, rin, ain, gin, addsub, done, err};
    return e;
  endfunction

  function automatic exp_t idle(input logic [8:0] ir);
    return mk(ir, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0);
  endfunction

  // Apply inputs just after an edge and queue the outputs expected this cycle.
  task automatic cyc(input logic rst, input logic run, input logic [15:0] din,
                     input exp_t e);
    @(posedge Clock);
    #1;
    Reset = rst;
    Run   = run;
    DIN   = din;
    q.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (q.size() > 0) begin
      mon_e   = q.pop_front();
      mon_got = '{IR, Rout, Gout, DINout, Rin, Ain, Gin, AddSub, Done, err_sig};
      n_cyc++;
      n_checks++;
      if (mon_got !== mon_e) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got ir=%h rout=%b gout=%b dinout=%b rin=%b ain=%b gin=%b addsub=%b done=%b err=%b, expected ir=%h rout=%b gout=%b dinout=%b rin=%b ain=%b gin=%b addsub=%b done=%b err=%b",
                 n_cyc, mon_got.ir, mon_got.rout, mon_got.gout, mon_got.dinout,
                 mon_got.rin, mon_got.ain, mon_got.gin, mon_got.addsub,
                 mon_got.done, mon_got.err, mon_e.ir, mon_e.rout, mon_e.gout,
                 mon_e.dinout, mon_e.rin, mon_e.ain, mon_e.gin, mon_e.addsub,
                 mon_e.done, mon_e.err);
      end else begin
        $display("cycle %0d ok: ir=%h rout=%b rin=%b done=%b", n_cyc, IR, Rout, Rin, Done);
      end
      n_checks++;
      if ((int'(DINout) + int'(Gout) + int'(|Rout)) > 1 || !$onehot0(Rout) || !$onehot0(Rin)) begin
        n_fail++;
        $display("FAIL bus_invariant cycle %0d: got dinout=%b gout=%b rout=%b rin=%b, expected single source and one-hot-or-zero selects",
                 n_cyc, DINout, Gout, Rout, Rin);
      end
    end
  end

  initial begin
    // Reset for two cycles, then idle with Run low.
    cyc(1, 0, 16'h0000, idle(9'h000));
    cyc(1, 0, 16'h0000, idle(9'h000));
    cyc(0, 0, 16'h01FF, idle(9'h000));
    cyc(0, 0, 16'h01FF, idle(9'h000));
    cyc(0, 0, 16'h01FF, idle(9'h000));

    // mvi R2,#D ; DIN changes in T1 must not touch IR.
    cyc(0, 1, 16'h0050, idle(9'h000));
    cyc(0, 0, 16'hFFFF, mk(9'h050, 8'h00, 0, 1, 8'b0010_0000, 0, 0, 0, 1, 0));
    cyc(0, 0, 16'h0000, idle(9'h050));

    // mv R1,R7 with Run held high through T1.
    cyc(0, 1, 16'h000F, idle(9'h050));
    cyc(0, 1, 16'h01FF, mk(9'h00F, 8'b0000_0001, 0, 0, 8'b0100_0000, 0, 0, 0, 1, 0));

    // sub R0,R5 issued back-to-back; Run high in T1/T2 is ignored.
    cyc(0, 1, 16'h00C5, idle(9'h00F));
    cyc(0, 1, 16'h01FF, mk(9'h0C5, 8'b1000_0000, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc(0, 1, 16'h0000, mk(9'h0C5, 8'b0000_0100, 0, 0, 8'h00, 0, 1, 1, 0, 0));
    cyc(0, 0, 16'h0000, mk(9'h0C5, 8'h00, 1, 0, 8'b1000_0000, 0, 0, 0, 1, 0));
    cyc(0, 0, 16'h0000, idle(9'h0C5));

    // mv R3,R3: X==Y.
    cyc(0, 1, 16'h001B, idle(9'h0C5));
    cyc(0, 0, 16'h0000, mk(9'h01B, 8'b0001_0000, 0, 0, 8'b0001_0000, 0, 0, 0, 1, 0));

    // add R4,R6 aborted by reset in T2, then mv R1,R7 runs normally.
    cyc(0, 1, 16'h00A6, idle(9'h01B));
    cyc(0, 0, 16'h0000, mk(9'h0A6, 8'b0000_1000, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc(1, 0, 16'h0000, idle(9'h0A6));
    cyc(0, 0, 16'h0000, idle(9'h000));
    cyc(0, 1, 16'h000F, idle(9'h000));
    cyc(0, 0, 16'h0000, mk(9'h00F, 8'b0000_0001, 0, 0, 8'b0100_0000, 0, 0, 0, 1, 0));

    // Full add R4,R6.
    cyc(0, 1, 16'h00A6, idle(9'h00F));
    cyc(0, 0, 16'h0000, mk(9'h0A6, 8'b0000_1000, 0, 0, 8'h00, 1, 0, 0, 0, 0));
    cyc(0, 0, 16'h0000, mk(9'h0A6, 8'b0000_0010, 0, 0, 8'h00, 0, 1, 0, 0, 0));
    cyc(0, 0, 16'h0000, mk(9'h0A6, 8'h00, 1, 0, 8'b0000_1000, 0, 0, 0, 1, 0));

    // Illegal opcode 110.
    cyc(0, 1, 16'h0180, idle(9'h0A6));
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 16'h0050, mk(9'h180, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1));
    cyc(1, 0, 16'h0000, idle(9'h180));
    cyc(0, 0, 16'h0000, idle(9'h000));
`else
    cyc(0, 0, 16'h0000, mk(9'h180, 8'h00, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    cyc(0, 0, 16'h0000, idle(9'h180));
`endif

    // Recovery: mvi R7,#D.
    cyc(0, 1, 16'h0078, idle(IR_AFTER_ILLEGAL()));
    cyc(0, 0, 16'h0000, mk(9'h078, 8'h00, 0, 1, 8'b0000_0001, 0, 0, 0, 1, 0));
    cyc(0, 0, 16'h0000, idle(9'h078));

    repeat (3) @(negedge Clock);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic logic [8:0] IR_AFTER_ILLEGAL();
`ifdef BUS_CTRL_ILLEGAL_TRAP_EN
    return 9'h000;
`else
    return 9'h180;
`endif
  endfunction

endmodule

// File: doc/bus_control_fsm.md
Name: bus_control_fsm

Overview:
- Control unit on the initiator side of the processor's shared 16-bit bus.
- Fetches a 9-bit instruction from DIN and steps through timesteps T0–T3.
- Drives the bus-source selects consumed by the bus multiplexer: Rout one-hot, Gout, DINout.
- Drives the sink enables: Rin one-hot, Ain, Gin, AddSub. Signals completion with Done.

Parameters:
- DATA_W, 16, width of DIN; only bits [8:0] are used.
- IR_W, 9, instruction width: opcode III = IR[8:6], X = IR[5:3], Y = IR[2:0].

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Run  in  1  start request, sampled only in T0
- DIN  in  DATA_W  external data/instruction word
- IR  out  IR_W  registered instruction
- Rout  out  8  one-hot bus source select; bit 7 = R0 … bit 0 = R7
- Gout  out  1  drive G onto bus
- DINout  out  1  drive DIN onto bus
- Rin  out  8  one-hot register load enable, same bit mapping as Rout
- Ain  out  1  load A from bus
- Gin  out  1  load G from ALU
- AddSub  out  1  0 = add, 1 = subtract (valid when Gin=1)
- Done  out  1  last cycle of instruction

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset=1 at an edge: state←T0, IR←0.
  - While Reset=1, all outputs except IR are forced to 0 combinationally.
- State: 2-bit timestep register T0..T3.
  - All control outputs are combinational decodes of the registered state and the registered IR; there is no DIN-to-output path.
- T0 (fetch):
  - All control outputs 0.
  - If Run=1: IR←DIN[8:0], state←T1. Otherwise hold T0 and IR.
- Register index n maps to bit (7-n) for both Rout and Rin.
- Opcode 000, mv Rx,Ry:
  - T1: Rout=onehot(Y), Rin=onehot(X), Done=1.
  - Next state T0.
- Opcode 001, mvi Rx,#D:
  - T1: DINout=1, Rin=onehot(X), Done=1.
  - Next state T0. The immediate is the DIN value present during T1.
- Opcode 010, add Rx,Ry:
  - T1: Rout=onehot(X), Ain=1.
  - T2: Rout=onehot(Y), Gin=1, AddSub=0.
  - T3: Gout=1, Rin=onehot(X), Done=1.
  - Next state T0.
- Opcode 011, sub Rx,Ry: same as add, except AddSub=1 in T2.
- Opcodes 100–111: see Optional Feature.
- Latency from the Run-sampled edge to Done high: 1 cycle for mv/mvi, 3 cycles for add/sub. Back-to-back issue is possible (Run=1 in the T0 that follows Done).
- Invariants, which hold every cycle:
  - At most one of {DINout, Gout, |Rout} is 1.
  - Rout and Rin are each 0 or exactly one-hot.
  - The bus multiplexer's priority is therefore never exercised.
- Boundary conditions:
  - Run is ignored in T1–T3. Holding Run=1 across an instruction does not re-fetch until T0.
  - Reset asserted in T1–T3 aborts the instruction; the next state is T0 with no Done.
  - X==Y is legal: mv R3,R3 gives Rout=Rin=8'b0001_0000.
  - DIN changes during T1–T3 do not alter IR.

Optional Feature:
- Macro: BUS_CTRL_ILLEGAL_TRAP_EN
- Defined:
  - Adds output port Error (1 bit, reset 0).
  - An opcode of 100–111 in T1 sets Error=1 (sticky until Reset) and asserts no control outputs, including Done.
  - The FSM then holds in T1 until Reset, ignoring Run.
- Undefined:
  - Opcodes 100–111 execute as a NOP: T1 asserts Done=1 only, then the FSM returns to T0.
  - The Error port does not exist.

Test Plan:
- Reset=1 for 2 cycles, then Run=0 for 3 cycles -> IR=0, every control output 0, FSM stays in T0.
- DIN=9'b001_010_000 (mvi R2), Run=1 -> next cycle: DINout=1, Rin=8'b0010_0000, Done=1, Rout=0; following cycle back in T0 with all outputs 0.
- DIN=9'b000_001_111 (mv R1,R7) -> T1: Rout=8'b0000_0001, Rin=8'b0100_0000, Done=1.
- DIN=9'b011_000_101 (sub R0,R5) -> T1: Rout=8'b1000_0000, Ain=1; T2: Rout=8'b0000_0100, Gin=1, AddSub=1; T3: Gout=1, Rin=8'b1000_0000, Done=1. The bus-source exclusivity check passes on every cycle.
- add R4,R6 started, Reset=1 at T2 -> next cycle T0, no Done, no Gout. A following mv issues normally.
- DIN=9'b110_000_000:
  - With macro: Error=1, FSM stays in T1, Done=0 for 5 cycles, recovery only after Reset.
  - Without macro: Done=1 alone in T1, then T0.
